lzd_seq_ctrl: RTL and testbench
===============================

# lzd_seq_ctrl

Sequential leading-zero counter for wide operands built around one shared 8-bit leading-zero slice. It accepts a WIDTH-bit operand over a valid/ready handshake and scans it one byte per cycle, MSB byte first, stopping at the first non-zero byte. It returns the total leading-zero count over a second valid/ready handshake. It sits in front of normalisation and shift logic in the arithmetic datapath, where area matters more than single-cycle latency.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of 8 and at least 8
- NB (derived), WIDTH/8, number of bytes in the operand
- CW (derived), $clog2(WIDTH+1), width of the count output
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  operand offered
- in_ready  out  1  block can accept an operand
- in_data  in  WIDTH  operand; bit WIDTH-1 is the MSB
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_count  out  CW  number of leading zeros, 0..WIDTH
- out_zero  out  1  operand was all-zero (out_count == WIDTH)

## Operation
- FSM states are IDLE, SCAN and DONE.
- Reset: state IDLE, out_valid=0, out_count=0, out_zero=0. While rst is high, in_ready=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, load in_data into the shift register sop, clear the byte index idx and the accumulator acc, then go to SCAN.
- SCAN (in_ready=0): the top byte sop[WIDTH-1:WIDTH-8] feeds the slice, which returns lz (0..7) and a zero flag. Each cycle:
  - Top byte non-zero: out_count ← acc+lz, out_zero ← 0, go to DONE.
  - Top byte zero and idx==NB-1: out_count ← WIDTH, out_zero ← 1, go to DONE.
  - Otherwise: acc ← acc+8, idx ← idx+1, sop ← sop<<8, stay in SCAN.
- DONE:
  - out_valid=1. out_count and out_zero are held stable until the handshake completes.
  - On out_ready, go to IDLE and clear out_valid.
  - out_count and out_zero keep their last values after the handshake and are don't-care while out_valid=0.
- No bypass: a new operand is never accepted in the same cycle that a result is consumed.
- Arithmetic:
  - acc is CW bits wide and only ever holds multiples of 8, at most WIDTH-8.
  - acc+lz never overflows CW bits.
  - idx is max(1,$clog2(NB)) bits wide.
- Reset mid-operation (rst in SCAN or DONE): the operand is dropped, no result is produced, and the block returns to reset values next cycle.
- Inputs are ignored outside IDLE; in_data is sampled only on the accept edge.

## Timing
- Operand accepted at edge t, first non-zero byte k (k=0 is the MSB byte): out_valid rises after edge t+1+k, i.e. latency k+2 cycles.
- All-zero operand: out_valid rises after edge t+NB, i.e. latency NB+1 cycles.
- Best case (non-zero MSB byte): 2 cycles from accept to out_valid.
- Result consumed at edge u: in_ready=1 from edge u onward, so the earliest next accept is edge u+1.
- Sustained throughput with out_ready held high: one operand per (latency+1) cycles.
- in_ready and out_valid are decoded from registered state only; no input-to-output combinational path.

## Structure
- Shared package lzd_pkg holds:
  - LZD_BYTE=8
  - the state typedef enum {IDLE, SCAN, DONE}
  - a function cw_of(width) returning $clog2(width+1)
- One sub-module lzd8_cnt: purely combinational, in 8 bits with bit 7 as MSB, out lz[2:0] (0..7) and zero. lz is don't-care when zero=1.
- The controller instantiates exactly one lzd8_cnt.
- Expected size: roughly 150 RTL lines (controller) plus 40 (slice).

## Test plan
- WIDTH=32, in_data=0x8000_0000, out_ready=1 → out_count=0, out_zero=0, out_valid exactly 2 cycles after accept.
- in_data=0x0000_0100 → out_count=23, latency 4 cycles; in_data=0x0000_0001 → out_count=31, latency 5 cycles.
- in_data=0x0000_0000 → out_count=32, out_zero=1, latency 5 cycles; then in_data=0x0001_0000 → out_count=15.
- Backpressure: out_ready=0 for 6 cycles after out_valid with in_data=0x00F0_0000 → out_count=8 held stable and in_ready=0 throughout; in_valid pulses with other data during this window are ignored.
- Reset mid-scan: accept 0x0000_0001, assert rst for 1 cycle at the second SCAN cycle → no out_valid afterwards, in_ready=1 the cycle after rst drops; the next operand 0x4000_0000 → out_count=1.
- Randomised back-to-back operands with random out_ready for WIDTH=8, 32 and 64, checked against a reference leading-zero model.

Source files
------------

// File: rtl/lzd_pkg.sv
// Shared types and helpers for the sequential leading-zero counter.
package lzd_pkg;

  // Bits scanned per cycle by the shared slice.
  localparam int unsigned LZD_BYTE = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } lzd_state_e;

  // Bits needed to hold a count of 0..width.
  function automatic int unsigned cw_of(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lzd8_cnt.sv
// Combinational leading-zero count of one byte; bit 7 is the MSB.
module lzd8_cnt (
  input  logic [7:0] data,
  output logic [2:0] lz,
  output logic       zero
);

  // Ascending scan so the highest set bit is the last to write lz.
  always_comb begin
    lz   = 3'd0;
    zero = (data == 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (data[i]) begin
        lz = 3'(7 - i);
      end
    end
  end

endmodule

// File: rtl/lzd_seq_ctrl.sv
// Sequential leading-zero counter: scans a WIDTH-bit operand one byte per
// cycle, MSB byte first, through a single shared 8-bit slice.
module lzd_seq_ctrl
  import lzd_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);

  localparam int unsigned NB = WIDTH / LZD_BYTE;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NB - 1);
  localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] BYTE_CNT  = CW'(LZD_BYTE);

  lzd_state_e       state_q;
  logic [WIDTH-1:0] sop_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    acc_q;
  logic [CW-1:0]    count_q;
  logic             zero_q;
  logic             ready_q;
  logic             valid_q;

  logic [2:0]       slice_lz;
  logic             slice_zero;

  lzd8_cnt u_slice (
    .data (sop_q[WIDTH-1 -: LZD_BYTE]),
    .lz   (slice_lz),
    .zero (slice_zero)
  );

  // Handshake flags are registered alongside the state so neither depends
  // combinationally on any input, including rst.
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_count = count_q;
  assign out_zero  = zero_q;

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sop_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (in_valid && ready_q) begin
            sop_q   <= in_data;
            idx_q   <= '0;
            acc_q   <= '0;
            ready_q <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (!slice_zero) begin
            count_q <= acc_q + CW'(slice_lz);
            zero_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else if (idx_q == LAST_IDX) begin
            count_q <= WIDTH_CNT;
            zero_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            acc_q <= acc_q + BYTE_CNT;
            idx_q <= idx_q + IW'(1);
            sop_q <= sop_q << LZD_BYTE;
          end
        end
        DONE: begin
          // No bypass: the accept can only happen from IDLE on a later edge.
          if (out_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzd_seq_ctrl.sv
// Bench for lzd_seq_ctrl: directed cases on a 32-bit instance plus
// randomized traffic on 8-, 32- and 64-bit instances against a bit-level
// leading-zero reference.
module tb_lzd_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- directed
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_count;
  logic        out_zero;

  lzd_seq_ctrl #(.WIDTH(32)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  // Offer one operand at a negedge; expect the given result and latency.
  // hold > 0 keeps out_ready low for that many cycles after out_valid.
  task automatic run_op(input logic [31:0] d, input int exp_cnt, input logic exp_zero,
                        input int exp_lat, input int hold, input string tag);
    int n;
    int j;
    logic [5:0] held;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ready"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    j = 0;
    while (!out_valid && j < 60) begin
      @(negedge clk);
      j++;
    end
    check_eq({tag, "_valid"}, out_valid, 1'b1);
    check_eq({tag, "_lat"}, j + 1, exp_lat);
    check_eq({tag, "_cnt"}, out_count, exp_cnt);
    check_eq({tag, "_zero"}, out_zero, exp_zero);
    held = out_count;
    for (int h = 0; h < hold; h++) begin
      check_eq({tag, "_hold_valid"}, out_valid, 1'b1);
      check_eq({tag, "_hold_cnt"}, out_count, held);
      check_eq({tag, "_hold_ready"}, in_ready, 1'b0);
      in_valid = h[0];
      in_data  = $urandom;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_release"}, out_valid, 1'b0);
    check_eq({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  bit dir_done = 1'b0;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_in_ready", in_ready, 1'b0);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_count", out_count, 6'd0);
      check_eq("rst_out_zero", out_zero, 1'b0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", in_ready, 1'b1);

    run_op(32'h8000_0000, 0, 1'b0, 2, 0, "msb");
    run_op(32'h0000_0100, 23, 1'b0, 4, 0, "b2");
    run_op(32'h0000_0001, 31, 1'b0, 5, 0, "b3");
    run_op(32'h0000_0000, 32, 1'b1, 5, 0, "allz");
    run_op(32'h0001_0000, 15, 1'b0, 3, 0, "after_z");
    run_op(32'h00F0_0000, 8, 1'b0, 3, 6, "bp");

    // Reset during the second SCAN cycle drops the operand.
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready_back", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_eq("mid_rst_no_result", out_valid, 1'b0);
      @(negedge clk);
    end
    run_op(32'h4000_0000, 1, 1'b0, 2, 0, "after_rst");
    dir_done = 1'b1;
  end

  // -------------------------------------------------------------- randomized
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W  = (g == 0) ? 8 : (g == 1) ? 32 : 64;
    localparam int CW = $clog2(W + 1);
    localparam int NB = W / 8;

    logic          r_rst;
    logic          r_in_valid;
    logic          r_in_ready;
    logic [W-1:0]  r_in_data;
    logic          r_out_valid;
    logic          r_out_ready;
    logic [CW-1:0] r_out_count;
    logic          r_out_zero;
    bit            done = 1'b0;

    lzd_seq_ctrl #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (r_rst),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready),
      .in_data   (r_in_data),
      .out_valid (r_out_valid),
      .out_ready (r_out_ready),
      .out_count (r_out_count),
      .out_zero  (r_out_zero)
    );

    initial begin
      logic [W-1:0] d;
      int exp_lz;
      int exp_lat;
      int j;
      int k;
      r_rst       = 1'b1;
      r_in_valid  = 1'b0;
      r_in_data   = '0;
      r_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      r_rst = 1'b0;
      @(negedge clk);
      for (int op = 0; op < 60; op++) begin
        check_eq($sformatf("rnd%0d_ready", W), r_in_ready, 1'b1);
        for (int b = 0; b < NB; b++) begin
          case ($urandom_range(0, 3))
            0:       d[8*b +: 8] = 8'($urandom);
            1:       d[8*b +: 8] = 8'h01 << $urandom_range(0, 7);
            default: d[8*b +: 8] = 8'h00;
          endcase
        end
        if ($urandom_range(0, 7) == 0) d = '0;

        // Reference: position of the highest set bit, whole-operand view.
        exp_lz = W;
        for (int i = 0; i < W; i++) begin
          if (d[i]) exp_lz = W - 1 - i;
        end
        exp_lat = (exp_lz == W) ? NB + 1 : exp_lz / 8 + 2;

        r_in_valid = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        r_in_valid = 1'b1;
        r_in_data  = d;
        @(posedge clk);
        @(negedge clk);
        j = 0;
        while (!r_out_valid && j < 100) begin
          r_in_valid  = $urandom_range(0, 1);
          r_in_data   = W'({$urandom, $urandom});
          r_out_ready = $urandom_range(0, 1);
          @(negedge clk);
          j++;
        end
        check_eq($sformatf("rnd%0d_lat", W), j + 1, exp_lat);
        k = 0;
        while (r_out_valid && k < 40) begin
          check_eq($sformatf("rnd%0d_cnt", W), r_out_count, exp_lz);
          check_eq($sformatf("rnd%0d_zero", W), r_out_zero, exp_lz == W);
          r_in_valid  = $urandom_range(0, 1);
          r_in_data   = W'({$urandom, $urandom});
          r_out_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          k++;
        end
        check_eq($sformatf("rnd%0d_release", W), r_out_valid, 1'b0);
      end
      r_in_valid = 1'b0;
      done = 1'b1;
    end
  end

  // ----------------------------------------------------------------- summary
  initial begin
    int n;
    n = 0;
    while (!(dir_done && g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check_eq("all_done", dir_done && g_rnd[0].done && g_rnd[1].done && g_rnd[2].done, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
